// File: rtl/hbf_mac_sched.sv
// -----------------------------------------------------------------------------
// hbf_mac_sched
//
// Round-robin scheduler that time-shares one multiply-accumulate unit between
// NUM_REQ half-band decimator stages. A granted stage gets NTAPS consecutive
// MAC cycles (tap-pair index 0..NTAPS-1), then the scheduler waits MAC_LAT
// cycles for the MAC pipeline to drain and pulses done to that stage.
//
// Job sequence: IDLE (arbitrate) -> MAC (NTAPS) -> FLUSH (MAC_LAT) -> DONE (1)
// FLUSH is skipped when MAC_LAT = 0.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   en         1 = new grants allowed; 0 = finish current job, then hold idle
//   req        per-stage request level, held until the matching done
//   grant      one-hot owner of the MAC, zero when idle
//   tap_idx    tap-pair index presented to the MAC this cycle
//   mac_en     MAC accumulates this cycle
//   mac_first  with mac_en: load product instead of accumulating
//   mac_last   with mac_en: final tap of the job
//   done       one-cycle pulse: accumulator result valid for granted stage
//   busy       scheduler is not idle
//
// All outputs come straight from flops; req/en only reach them through the
// next-state logic.
// -----------------------------------------------------------------------------
module hbf_mac_sched #(
    parameter  int unsigned NUM_REQ = 3,
    parameter  int unsigned NTAPS   = 4,
    parameter  int unsigned MAC_LAT = 2,
    localparam int unsigned TW      = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [TW-1:0]      tap_idx,
    output logic               mac_en,
    output logic               mac_first,
    output logic               mac_last,
    output logic [NUM_REQ-1:0] done,
    output logic               busy
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      cnt_q, cnt_d;        // tap-pair counter
    logic [LW-1:0]      fcnt_q, fcnt_d;      // pipeline flush counter
    logic [PW-1:0]      ptr_q, ptr_d;        // round-robin search start
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [TW-1:0]      tap_idx_q, tap_idx_d;
    logic               mac_en_q, mac_en_d;
    logic               mac_first_q, mac_first_d;
    logic               mac_last_q, mac_last_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;

    // Arbitration result
    logic               win_found;
    logic [PW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    int unsigned        cand;

    // -------------------------------------------------------------------------
    // Round-robin search: first set req[k] for k = ptr, ptr+1, ... mod NUM_REQ
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {{(32-PW){1'b0}}, ptr_q} + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
        win_onehot = NUM_REQ'(1) << win_idx;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;

        unique case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (en && win_found) begin
                    state_d = S_MAC;
                    cnt_d   = '0;
                    grant_d = win_onehot;
                    ptr_d   = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
                end
            end

            S_MAC: begin
                if (cnt_q == TW'(NTAPS - 1)) begin
                    cnt_d   = '0;
                    fcnt_d  = '0;
                    state_d = (MAC_LAT == 0) ? S_DONE : S_FLUSH;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end

            S_FLUSH: begin
                if (fcnt_q == LW'(MAC_LAT - 1)) begin
                    fcnt_d  = '0;
                    state_d = S_DONE;
                end else begin
                    fcnt_d = fcnt_q + LW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode of the *next* state, so every output is a flop
    // -------------------------------------------------------------------------
    always_comb begin
        mac_en_d    = (state_d == S_MAC);
        tap_idx_d   = mac_en_d ? cnt_d : '0;
        mac_first_d = mac_en_d && (cnt_d == '0);
        mac_last_d  = mac_en_d && (cnt_d == TW'(NTAPS - 1));
        done_d      = (state_d == S_DONE) ? grant_d : '0;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            tap_idx_q   <= '0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            done_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            tap_idx_q   <= tap_idx_d;
            mac_en_q    <= mac_en_d;
            mac_first_q <= mac_first_d;
            mac_last_q  <= mac_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign tap_idx   = tap_idx_q;
    assign mac_en    = mac_en_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule
